// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite sequencer: FSM states, special frames
// and the per-frame sprite size table.
package duck_pkg;

   typedef enum logic [2:0] {IDLE, FLY, SHOT, FALL, DONE} duck_state_t;

   localparam logic [4:0] FRAME_SHOT    = 5'd8;
   localparam logic [4:0] FRAME_FALL    = 5'd9;
   localparam logic [6:0] DUCK_H        = 7'd64;
   localparam logic [6:0] DUCK_W_NARROW = 7'd64;
   localparam logic [6:0] DUCK_W_WIDE   = 7'd68;

   // Climbing flap frames (4-7) carry wider wings than every other frame.
   function automatic logic [6:0] duck_width(input logic [4:0] frame);
      return (frame >= 5'd4 && frame <= 5'd7) ? DUCK_W_WIDE : DUCK_W_NARROW;
   endfunction

endpackage

// File: rtl/duck_addr_gen.sv
// Two-stage pipeline: draw coordinate -> sprite-local ROM address (stage 1),
// then a hit flag delayed to line up with the ROM's registered q (stage 2).
module duck_addr_gen
   import duck_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        active,
   input  logic        face_left,
   input  logic [4:0]  frame,
   input  logic [9:0]  duck_x,
   input  logic [9:0]  duck_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [13:0] rom_address,
   output logic        pix_valid
);

   logic signed [10:0] dx;
   logic signed [10:0] dy;
   logic [6:0]         width;
   logic [6:0]         dxm;
   logic               in_box;
   logic               in_q;
   logic [13:0]        addr_next;

   assign dx    = $signed({1'b0, draw_x}) - $signed({1'b0, duck_x});
   assign dy    = $signed({1'b0, draw_y}) - $signed({1'b0, duck_y});
   assign width = duck_width(frame);

   assign in_box = active && !dx[10] && !dy[10] &&
                   (dx[9:0] < {3'b000, width}) && (dy[9:0] < {3'b000, DUCK_H});

   // Only meaningful when in_box, where dx < 68 always fits in 7 bits.
   assign dxm = face_left ? (width - 7'd1 - dx[6:0]) : dx[6:0];

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      addr_next = '0;
      if (width == DUCK_W_NARROW)
         addr_next = {2'b00, dy[5:0], dxm[5:0]};
      else
         addr_next = ({8'b0, dy[5:0]} << 6) + ({8'b0, dy[5:0]} << 2) + {7'b0, dxm};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rom_address <= '0;
         in_q        <= 1'b0;
         pix_valid   <= 1'b0;
      end else begin
         rom_address <= in_box ? addr_next : 14'd0;
         in_q        <= in_box;
         pix_valid   <= in_q && active;
      end
   end

endmodule

// File: rtl/duck_sprite_sequencer.sv
// Duck animation FSM (flap / shot pose / fall) driving the sprite ROM frame select,
// plus the coordinate-to-address pipeline feeding the ROM.
module duck_sprite_sequencer
   import duck_pkg::*;
#(
   parameter int FLAP_DIV  = 6,
   parameter int SHOT_HOLD = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        launch,
   input  logic        shot,
   input  logic        climb,
   input  logic        face_left,
   input  logic        landed,
   input  logic [9:0]  duck_x,
   input  logic [9:0]  duck_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [4:0]  frame,
   output logic [13:0] rom_address,
   output logic        pix_valid,
   output logic        active,
   output logic        done
);

   localparam logic [5:0] FLAP_LAST = 6'(FLAP_DIV - 1);
   localparam logic [7:0] HOLD_LAST = 8'(SHOT_HOLD - 1);

   duck_state_t state;
   logic [5:0]  flap_cnt;
   logic [1:0]  phase;
   logic [7:0]  hold_cnt;

   assign active = (state == FLY) || (state == SHOT) || (state == FALL);

   // Frame only changes on a frame_tick or a state entry, never mid-scanline.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         frame    <= '0;
         flap_cnt <= '0;
         phase    <= '0;
         hold_cnt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (launch) begin
                  state    <= FLY;
                  flap_cnt <= '0;
                  phase    <= '0;
                  frame    <= {2'b00, climb, 2'b00};
               end
            end
            FLY: begin
               // A shot beats a coincident frame_tick; the hold count starts from zero.
               if (shot) begin
                  state    <= SHOT;
                  hold_cnt <= '0;
                  frame    <= FRAME_SHOT;
               end else if (frame_tick) begin
                  if (flap_cnt == FLAP_LAST) begin
                     flap_cnt <= '0;
                     phase    <= phase + 2'd1;
                     frame    <= {2'b00, climb, phase + 2'd1};
                  end else begin
                     flap_cnt <= flap_cnt + 6'd1;
                     frame    <= {2'b00, climb, phase};
                  end
               end
            end
            SHOT: begin
               if (frame_tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state <= FALL;
                     frame <= FRAME_FALL;
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
            end
            FALL: begin
               if (landed) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   duck_addr_gen u_addr_gen (
      .clock       (clock),
      .reset       (reset),
      .active      (active),
      .face_left   (face_left),
      .frame       (frame),
      .duck_x      (duck_x),
      .duck_y      (duck_y),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .rom_address (rom_address),
      .pix_valid   (pix_valid)
   );

endmodule

// File: tb/tb_duck_sprite_sequencer.sv
// Directed bench for duck_sprite_sequencer: reset, flap cadence, shot/fall sequence,
// address mapping with mirroring, and ignored control pulses.
module tb_duck_sprite_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        launch = 1'b0;
   logic        shot = 1'b0;
   logic        climb = 1'b0;
   logic        face_left = 1'b0;
   logic        landed = 1'b0;
   logic [9:0]  duck_x = '0;
   logic [9:0]  duck_y = '0;
   logic [9:0]  draw_x = 10'd500;
   logic [9:0]  draw_y = 10'd400;
   logic [4:0]  frame;
   logic [13:0] rom_address;
   logic        pix_valid;
   logic        active;
   logic        done;

   int pass_count  = 0;
   int check_count = 0;

   duck_sprite_sequencer #(.FLAP_DIV(6), .SHOT_HOLD(30)) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .launch      (launch),
      .shot        (shot),
      .climb       (climb),
      .face_left   (face_left),
      .landed      (landed),
      .duck_x      (duck_x),
      .duck_y      (duck_y),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .frame       (frame),
      .rom_address (rom_address),
      .pix_valid   (pix_valid),
      .active      (active),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) pass_count++;
      else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic pulse_launch();
      launch = 1'b1;
      step();
      launch = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      step(3);
      reset = 1'b0;
      step();
      check("reset_frame", frame, 0);
      check("reset_active", active, 0);
      check("reset_addr", rom_address, 0);
      check("reset_valid", pix_valid, 0);
      check("reset_done", done, 0);

      // Reset in the middle of a flight at phase 2.
      pulse_launch();
      check("launch_active", active, 1);
      for (int k = 0; k < 12; k++) tick();
      check("pre_reset_frame", frame, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_frame", frame, 0);
      check("midreset_active", active, 0);
      check("midreset_valid", pix_valid, 0);
      check("midreset_done", done, 0);

      // Level flap cadence: each frame held for 6 ticks, wrapping back to 0.
      pulse_launch();
      check("fly_start_frame", frame, 0);
      for (int k = 1; k <= 24; k++) begin
         tick();
         check($sformatf("flap_tick%0d", k), frame, (k / 6) % 4);
      end

      // Address mapping in frame 0 at the bottom-right corner and one pixel past it.
      duck_x = 10'd100; duck_y = 10'd50;
      draw_x = 10'd163; draw_y = 10'd113;
      step();
      check("corner_addr", rom_address, 4095);
      check("corner_valid_early", pix_valid, 0);
      step();
      check("corner_valid", pix_valid, 1);
      draw_x = 10'd164;
      step();
      check("past_edge_addr", rom_address, 0);
      step();
      check("past_edge_valid", pix_valid, 0);

      // Climb only takes effect on the next frame_tick.
      climb = 1'b1;
      step(2);
      check("climb_no_tick", frame, 0);
      tick();
      check("climb_tick1", frame, 4);
      for (int k = 0; k < 5; k++) tick();
      check("climb_tick6", frame, 5);

      // Wide frame 5 with mirroring.
      duck_x = '0; duck_y = '0;
      draw_x = 10'd0; draw_y = 10'd1;
      face_left = 1'b1;
      step();
      check("mirror_addr", rom_address, 135);
      step();
      check("mirror_valid", pix_valid, 1);
      face_left = 1'b0;
      step();
      check("unmirror_addr", rom_address, 68);

      // Shot coincident with frame_tick: shot wins, hold starts at zero.
      frame_tick = 1'b1; shot = 1'b1;
      step();
      frame_tick = 1'b0; shot = 1'b0;
      check("shot_frame", frame, 8);
      for (int k = 0; k < 14; k++) tick();
      shot = 1'b1; launch = 1'b1;
      step();
      shot = 1'b0; launch = 1'b0;
      check("shot_ignored_frame", frame, 8);
      check("shot_ignored_active", active, 1);
      for (int k = 0; k < 15; k++) tick();
      check("hold_29_frame", frame, 8);
      tick();
      check("hold_30_frame", frame, 9);
      check("fall_addr", rom_address, 64);
      check("fall_valid", pix_valid, 1);

      // Launch during FALL is ignored.
      pulse_launch();
      tick();
      check("fall_launch_frame", frame, 9);
      check("fall_launch_active", active, 1);
      check("fall_done_low", done, 0);

      landed = 1'b1;
      step();
      landed = 1'b0;
      check("done_pulse", done, 1);
      check("done_active", active, 0);
      check("done_frame_hold", frame, 9);
      step();
      check("done_pulse_end", done, 0);
      step();
      check("done_valid", pix_valid, 0);

      pulse_launch();
      check("relaunch_active", active, 1);
      check("relaunch_frame", frame, 4);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
